// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH stages of WIDTH bits with a valid bit per stage, bubble collapsing and synchronous flush.
// Optional registered occupancy port is enabled by defining PIPE_REG_OCC_EN.
module pipe_reg_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  // Handshake: a word moves across a port on a rising edge only when valid and ready are both high
  // in the preceding cycle; valid must not depend on ready, and ready here never depends on in_valid/in_data.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // A stage may load when it is empty or the stage in front of it is moving on.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !v[i] | adv[i+1];
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid & !flush;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
    v_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_nxt[i] = flush ? 1'b0 : (adv[i] ? src_v[i] : v[i]);
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Flush only clears valid bits; payload registers keep their contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      v <= v_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i] && !flush) begin
          d[i] <= src_d[i];
        end
      end
    end
  end

`ifdef PIPE_REG_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nxt;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_nxt[i]) begin
        occ_nxt = occ_nxt + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      occ <= occ_nxt;
    end
  end

  assign occupancy = occ;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios plus random traffic,
// checked against a queue-based model of the chain's ordering and timing.
module tb_pipe_reg_chain;

  localparam int W = 64;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_OCC_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state: words in flight, in order, with the edge each was accepted on.
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           edge_cnt = 0;
  int           last_dep = 0;
  bit           exp_rdy  = 1'b0;
  bit           mon_en   = 1'b0;
  int           checks   = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge: reset/flush empty the chain, otherwise an accepted word joins the tail.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mon_en) begin
      if (reset || flush) begin
        exp_q.delete();
        acc_q.delete();
        last_dep <= 0;
      end else if (in_valid && exp_rdy) begin
        exp_q.push_back(in_data);
        acc_q.push_back(edge_cnt + 1);
      end
    end
  end

  // Monitor: the head word is visible once it has crossed all stages and its predecessor has left.
  always @(negedge clk) begin
    bit exp_v;
    if (mon_en) begin
      exp_v = (exp_q.size() > 0) && (edge_cnt >= acc_q[0] + D - 1) && (edge_cnt >= last_dep);
      check("out_valid", W'(out_valid), W'(exp_v));
      if (out_valid && exp_v) check("out_data", out_data, exp_q[0]);
      exp_rdy = !flush && ((exp_q.size() < D) || out_ready);
      check("in_ready", W'(in_ready), W'(exp_rdy));
`ifdef PIPE_REG_OCC_EN
      check("occupancy", W'(occupancy), W'(exp_q.size()));
`endif
      if (out_valid && out_ready && !reset && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        last_dep = edge_cnt + 1;
      end
    end
  end

  // Driver
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic fl, input logic rs);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
`ifdef PIPE_REG_OCC_EN
    check("rst_occupancy", W'(occupancy), '0);
`endif
    @(posedge clk);
    #1;

    // Streaming
    for (int k = 1; k <= 3; k++) cyc(1'b1, W'(k), 1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure fill; the extra word is offered while full
    for (int k = 5; k <= 9; k++) cyc(1'b1, W'(k), 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Bubble collapse
    cyc(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush a full chain, then flush a full chain while the head is delivered
    for (int k = 0; k < D; k++) cyc(1'b1, W'(16'h100 + k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hF1, 1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < D; k++) cyc(1'b1, W'(16'h200 + k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hF2, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation together with flush and out_ready
    for (int k = 0; k < 3; k++) cyc(1'b1, W'(16'h300 + k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hEE, 1'b1, 1'b1, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", W'(out_valid), '0);
    check("midrst_out_data", out_data, '0);
    @(posedge clk);
    #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    // Drain
    repeat (D + 4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", W'(exp_q.size()), '0);
    check("drain_out_valid", W'(out_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
